datapath_controller: RTL
========================

DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 Parameter WORDSIZE, 64, data word width in bits.
REQ-002 Parameter SIZE, 32, number of data memory / register file entries (addresses are 5 bits).
REQ-003 Single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one operation; sampled only in IDLE.
REQ-007 op  input  1  1 = subtract (a-b), 0 = add (a+b).
REQ-008 src_a_addr, src_b_addr, dst_addr  input  5 each  memory addresses for operand A, operand B and result.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 result  output  WORDSIZE  last computed value.
REQ-012 overflow  output  1  signed overflow of last operation.
REQ-013 op_count  output  16  completed operations, wraps at 65535 to 0.
REQ-014 dm_addr  output  5; dm_data_input  output  WORDSIZE; dm_write_enable  output  1; dm_read  output  1; dm_data_output  input  WORDSIZE -- data memory port.
REQ-015 rf_write_en  output  1; rf_write_addr  output  5; rf_write_data  output  WORDSIZE; rf_addr_a, rf_addr_b  output  5; rf_data_a, rf_data_b  input  WORDSIZE -- register file port.
REQ-016 factor_a, factor_b  output  WORDSIZE; operation  output  1; adder_result  input  WORDSIZE -- adder_subtractor port.

Function
REQ-017 Data memory read is registered: dm_data_output is valid the cycle after dm_addr is presented with dm_read=1. Memory and register file writes occur on the clk edge when the write enable is high. Register file reads and the adder are combinational.
REQ-018 States: IDLE, RD_A, WR_A, RD_B, WR_B, EXEC, STORE, DONE. All transitions occur on the rising edge of clk.
REQ-019 IDLE -> RD_A when start=1. On that edge, op, src_a_addr, src_b_addr and dst_addr are latched; later changes to these inputs are ignored until the next IDLE.
REQ-020 Without reset, RD_A->WR_A->RD_B->WR_B->EXEC->STORE->DONE->IDLE advance unconditionally, one state per cycle.
REQ-021 RD_A: dm_addr=latched src_a, dm_read=1, dm_write_enable=0.
REQ-022 WR_A: rf_write_en=1, rf_write_addr=0, rf_write_data=dm_data_output.
REQ-023 RD_B: dm_addr=latched src_b, dm_read=1.
REQ-024 WR_B: rf_write_en=1, rf_write_addr=1, rf_write_data=dm_data_output.
REQ-025 EXEC: rf_addr_a=0, rf_addr_b=1, factor_a=rf_data_a, factor_b=rf_data_b, operation=latched op. On the exit edge, result<=adder_result and overflow is updated.
REQ-026 STORE: dm_addr=latched dst, dm_data_input=result, dm_write_enable=1.
REQ-027 DONE: done=1; op_count increments on the exit edge.
REQ-028 In all states not listed above, every write enable and dm_read is 0. Address and data outputs hold their last value.
REQ-029 Latency: start sampled on edge k gives done high for the cycle after edge k+6, i.e. 7 cycles start-to-done. Throughput is one operation per 8 cycles.
REQ-030 start is ignored in every non-IDLE state; no queueing.
REQ-031 Arithmetic is modulo 2^WORDSIZE.
REQ-032 overflow=1 iff, after operation-adjusting the sign of b, the operand signs are equal and the result sign differs.
REQ-033 src_a_addr, src_b_addr and dst_addr may be equal. Both reads complete before STORE, so the operands are the pre-write values.

Reset
REQ-034 reset=1 on an edge forces IDLE from any state, aborting any operation without a STORE write.
REQ-035 Reset values: ready=1, done=0, result=0, overflow=0, op_count=0, all enables and dm_read 0, all addresses 0, data outputs 0.
REQ-036 reset has priority over start on the same edge.

Verification
REQ-037 mem[2]=5, mem[3]=7, start with op=0, a=2, b=3, dst=4 -> done exactly 7 cycles after start; result=12; mem[4]=12; op_count=1.
REQ-038 mem[2]=5, mem[3]=7, op=1, dst=2 -> result=-2 (all ones except LSB 0); mem[2]=0xFFFF_FFFF_FFFF_FFFE.
REQ-039 a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> result=0x8000_0000_0000_0000, overflow=1.
REQ-040 start held high for 20 cycles -> exactly 2 operations complete (done at cycles 7 and 15); inputs changed mid-operation do not affect the result.
REQ-041 reset asserted in EXEC -> next cycle IDLE, ready=1, dst memory unchanged, op_count unchanged.
REQ-042 65536 back-to-back operations -> op_count wraps to 0.

Source files
------------

// File: rtl/datapath_controller.sv
// Sequences one add/subtract: load two operands from data memory into register
// file entries 0 and 1, run them through the external adder, then store the result.
module datapath_controller #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic [$clog2(SIZE)-1:0] src_a_addr,
  input  logic [$clog2(SIZE)-1:0] src_b_addr,
  input  logic [$clog2(SIZE)-1:0] dst_addr,
  output logic                    ready,
  output logic                    done,
  output logic [WORDSIZE-1:0]     result,
  output logic                    overflow,
  output logic [15:0]             op_count,
  output logic [$clog2(SIZE)-1:0] dm_addr,
  output logic [WORDSIZE-1:0]     dm_data_input,
  output logic                    dm_write_enable,
  output logic                    dm_read,
  input  logic [WORDSIZE-1:0]     dm_data_output,
  output logic                    rf_write_en,
  output logic [$clog2(SIZE)-1:0] rf_write_addr,
  output logic [WORDSIZE-1:0]     rf_write_data,
  output logic [$clog2(SIZE)-1:0] rf_addr_a,
  output logic [$clog2(SIZE)-1:0] rf_addr_b,
  input  logic [WORDSIZE-1:0]     rf_data_a,
  input  logic [WORDSIZE-1:0]     rf_data_b,
  output logic [WORDSIZE-1:0]     factor_a,
  output logic [WORDSIZE-1:0]     factor_b,
  output logic                    operation,
  input  logic [WORDSIZE-1:0]     adder_result,
  output logic [2:0]              state_dbg
);

  localparam int AW = $clog2(SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_WR_A, S_RD_B, S_WR_B, S_EXEC, S_STORE, S_DONE
  } state_t;

  state_t              state;
  logic                op_q;
  logic [AW-1:0]       src_a_q, src_b_q, dst_q;
  logic [WORDSIZE-1:0] rf_wdata_q, fa_q, fb_q;
  logic                b_sign_adj, ovf_next;

  assign state_dbg = state;

  // Memory read data and register-file read data only arrive during the cycle
  // they are used, so those outputs pass through live and hold afterwards.
  always_comb begin
    rf_write_data = rf_wdata_q;
    factor_a      = fa_q;
    factor_b      = fb_q;
    if (state == S_WR_A || state == S_WR_B) rf_write_data = dm_data_output;
    if (state == S_EXEC) begin
      factor_a = rf_data_a;
      factor_b = rf_data_b;
    end
  end

  // Subtraction flips the effective sign of b before the same-sign test.
  assign b_sign_adj = rf_data_b[WORDSIZE-1] ^ operation;
  assign ovf_next   = (rf_data_a[WORDSIZE-1] == b_sign_adj) &&
                      (adder_result[WORDSIZE-1] != rf_data_a[WORDSIZE-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      op_q            <= 1'b0;
      src_a_q         <= '0;
      src_b_q         <= '0;
      dst_q           <= '0;
      rf_wdata_q      <= '0;
      fa_q            <= '0;
      fb_q            <= '0;
      ready           <= 1'b1;
      done            <= 1'b0;
      result          <= '0;
      overflow        <= 1'b0;
      op_count        <= '0;
      dm_addr         <= '0;
      dm_data_input   <= '0;
      dm_write_enable <= 1'b0;
      dm_read         <= 1'b0;
      rf_write_en     <= 1'b0;
      rf_write_addr   <= '0;
      rf_addr_a       <= '0;
      rf_addr_b       <= '0;
      operation       <= 1'b0;
    end else begin
      dm_read         <= 1'b0;
      dm_write_enable <= 1'b0;
      rf_write_en     <= 1'b0;
      done            <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          op_q    <= op;
          src_a_q <= src_a_addr;
          src_b_q <= src_b_addr;
          dst_q   <= dst_addr;
          ready   <= 1'b0;
          dm_addr <= src_a_addr;
          dm_read <= 1'b1;
          state   <= S_RD_A;
        end
        S_RD_A: begin
          rf_write_en   <= 1'b1;
          rf_write_addr <= AW'(0);
          state         <= S_WR_A;
        end
        S_WR_A: begin
          rf_wdata_q <= dm_data_output;
          dm_addr    <= src_b_q;
          dm_read    <= 1'b1;
          state      <= S_RD_B;
        end
        S_RD_B: begin
          rf_write_en   <= 1'b1;
          rf_write_addr <= AW'(1);
          state         <= S_WR_B;
        end
        S_WR_B: begin
          rf_wdata_q <= dm_data_output;
          rf_addr_a  <= AW'(0);
          rf_addr_b  <= AW'(1);
          operation  <= op_q;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          fa_q            <= rf_data_a;
          fb_q            <= rf_data_b;
          result          <= adder_result;
          overflow        <= ovf_next;
          dm_addr         <= dst_q;
          dm_data_input   <= adder_result;
          dm_write_enable <= 1'b1;
          state           <= S_STORE;
        end
        S_STORE: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          op_count <= op_count + 16'd1;
          ready    <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
